// File: rtl/uart_rx_deframer.sv
// Packet deframer behind the UART receiver: SYNC, LEN, payload, CHK framing.
// Payload is buffered and released over valid/ready only after the checksum matches.
module uart_rx_deframer #(
  parameter int         p_MAX_LEN      = 16,
  parameter logic [7:0] p_SYNC         = 8'hA5,
  parameter int         p_TIMEOUT_CLKS = 4340
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Rx_Completed,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Data_Valid,
  input  logic       i_Data_Ready,
  output logic [7:0] o_Data,
  output logic       o_Data_Last,
  output logic       o_Err_Checksum,
  output logic       o_Err_Length,
  output logic       o_Err_Timeout,
  output logic       o_Err_Overrun,
  output logic       o_Busy,
  output logic [2:0] o_State
);

  localparam int AW = (p_MAX_LEN > 1) ? $clog2(p_MAX_LEN) : 1;
  localparam int TW = (p_TIMEOUT_CLKS > 1) ? $clog2(p_TIMEOUT_CLKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHK     = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t        state;
  logic [7:0]    len_m1;
  logic [7:0]    sum;
  logic [7:0]    wr_ptr;
  logic [7:0]    rd_ptr;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    mem [p_MAX_LEN];

  logic counting;
  logic tmo_hit;
  logic last;

  // Handshake: o_Data moves when o_Data_Valid && i_Data_Ready on a rising edge;
  // o_Data/o_Data_Last hold while o_Data_Valid is high and i_Data_Ready is low.
  assign counting = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
  assign tmo_hit  = counting && !i_Rx_Completed && (tmo_cnt == TW'(p_TIMEOUT_CLKS - 1));
  assign last     = (rd_ptr == len_m1);
  assign o_State  = state;

  always_comb begin
    o_Data      = 8'h00;
    o_Data_Last = 1'b0;
    if (state == S_DRAIN) begin
      o_Data      = mem[rd_ptr[AW-1:0]];
      o_Data_Last = last;
    end
  end

  // Buffer has no reset: it is only read after a full, checked write pass.
  always_ff @(posedge i_Clk) begin
    if (state == S_PAYLOAD && i_Rx_Completed)
      mem[wr_ptr[AW-1:0]] <= i_Rx_Byte;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state          <= S_IDLE;
      len_m1         <= 8'h00;
      sum            <= 8'h00;
      wr_ptr         <= 8'h00;
      rd_ptr         <= 8'h00;
      tmo_cnt        <= '0;
      o_Data_Valid   <= 1'b0;
      o_Err_Checksum <= 1'b0;
      o_Err_Length   <= 1'b0;
      o_Err_Timeout  <= 1'b0;
      o_Err_Overrun  <= 1'b0;
      o_Busy         <= 1'b0;
    end else begin
      o_Err_Checksum <= 1'b0;
      o_Err_Length   <= 1'b0;
      o_Err_Timeout  <= 1'b0;
      o_Err_Overrun  <= 1'b0;
      if (counting)
        tmo_cnt <= i_Rx_Completed ? '0 : tmo_cnt + TW'(1);

      if (tmo_hit) begin
        state         <= S_IDLE;
        o_Busy        <= 1'b0;
        o_Err_Timeout <= 1'b1;
        tmo_cnt       <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_Rx_Completed && i_Rx_Byte == p_SYNC) begin
              state   <= S_LEN;
              o_Busy  <= 1'b1;
              tmo_cnt <= '0;
            end
          end
          S_LEN: begin
            if (i_Rx_Completed) begin
              if (i_Rx_Byte == 8'h00 || i_Rx_Byte > 8'(p_MAX_LEN)) begin
                state        <= S_IDLE;
                o_Busy       <= 1'b0;
                o_Err_Length <= 1'b1;
              end else begin
                len_m1 <= i_Rx_Byte - 8'd1;
                sum    <= i_Rx_Byte;
                wr_ptr <= 8'h00;
                state  <= S_PAYLOAD;
              end
            end
          end
          S_PAYLOAD: begin
            if (i_Rx_Completed) begin
              sum    <= sum + i_Rx_Byte;
              wr_ptr <= wr_ptr + 8'd1;
              if (wr_ptr == len_m1)
                state <= S_CHK;
            end
          end
          S_CHK: begin
            if (i_Rx_Completed) begin
              if (i_Rx_Byte == sum) begin
                state        <= S_DRAIN;
                rd_ptr       <= 8'h00;
                o_Data_Valid <= 1'b1;
              end else begin
                state          <= S_IDLE;
                o_Busy         <= 1'b0;
                o_Err_Checksum <= 1'b1;
              end
            end
          end
          S_DRAIN: begin
            // Any byte arriving while draining is dropped, SYNC included.
            if (i_Rx_Completed)
              o_Err_Overrun <= 1'b1;
            if (o_Data_Valid && i_Data_Ready) begin
              if (last) begin
                state        <= S_IDLE;
                o_Data_Valid <= 1'b0;
                o_Busy       <= 1'b0;
              end else begin
                rd_ptr <= rd_ptr + 8'd1;
              end
            end
          end
          default: begin
            state        <= S_IDLE;
            o_Data_Valid <= 1'b0;
            o_Busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Randomized scoreboard bench for uart_rx_deframer: a frame-level reference model
// predicts payload bytes and error pulses; a negedge monitor pops and compares.
module tb_uart_rx_deframer;

  localparam int         MAX_LEN = 16;
  localparam logic [7:0] SYNC    = 8'hA5;
  localparam int         TMO     = 4340;
  localparam int E_CHK = 1, E_LEN = 2, E_TMO = 3, E_OVR = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_stb = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       ready = 1'b1;
  logic       o_Data_Valid, o_Data_Last, o_Busy;
  logic [7:0] o_Data;
  logic       o_Err_Checksum, o_Err_Length, o_Err_Timeout, o_Err_Overrun;
  logic [2:0] o_State;

  logic [8:0] exp_q[$];
  int         err_q[$];
  logic [7:0] frame_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int ready_mode = 0;
  int tog_idx = 0;

  uart_rx_deframer #(.p_MAX_LEN(MAX_LEN), .p_SYNC(SYNC), .p_TIMEOUT_CLKS(TMO)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Rx_Completed(rx_stb), .i_Rx_Byte(rx_byte),
    .o_Data_Valid(o_Data_Valid), .i_Data_Ready(ready), .o_Data(o_Data),
    .o_Data_Last(o_Data_Last), .o_Err_Checksum(o_Err_Checksum),
    .o_Err_Length(o_Err_Length), .o_Err_Timeout(o_Err_Timeout),
    .o_Err_Overrun(o_Err_Overrun), .o_Busy(o_Busy), .o_State(o_State)
  );

  // clock / reset support
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ready pattern generator
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: ready = 1'b1;
        1: ready = 1'($urandom_range(0, 1));
        default: begin
          ready = (tog_idx % 3 == 0);
          tog_idx++;
        end
      endcase
    end
  end

  // monitor / scoreboard
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  task automatic check_err(input int code);
    if (err_q.size() == 0) check("err_unexpected", code, 0);
    else check("err_kind", code, err_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", o_Data_Valid, 1);
        check("stall_data", o_Data, prev_data);
        check("stall_last", o_Data_Last, prev_last);
      end
      if (exp_q.size() == 0) check("no_valid", o_Data_Valid, 0);
      else if (o_Data_Valid && ready) check("data", {o_Data_Last, o_Data}, exp_q.pop_front());
      if (o_Err_Checksum) check_err(E_CHK);
      if (o_Err_Length)   check_err(E_LEN);
      if (o_Err_Timeout)  check_err(E_TMO);
      if (o_Err_Overrun)  check_err(E_OVR);
      prev_stall = o_Data_Valid && !ready;
      prev_data  = o_Data;
      prev_last  = o_Data_Last;
    end
  end

  // reference model: frame rules applied to a whole frame at once
  task automatic model_frame();
    int len;
    int total;
    len = int'(frame_q[1]);
    if (len == 0 || len > MAX_LEN) begin
      err_q.push_back(E_LEN);
    end else if (frame_q.size() < len + 3) begin
      err_q.push_back(E_TMO);
    end else begin
      total = len;
      for (int i = 0; i < len; i++) total += int'(frame_q[2 + i]);
      if (frame_q[len + 2] == 8'(total % 256)) begin
        for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), frame_q[2 + i]});
      end else begin
        err_q.push_back(E_CHK);
      end
    end
  endtask

  // drivers: all called at 1 time unit after a rising edge
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_stb  = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    rx_stb  = 1'b0;
    rx_byte = 8'($urandom_range(0, 255));
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int max_gap);
    for (int i = 0; i < frame_q.size(); i++)
      send_byte(frame_q[i], (i == frame_q.size() - 1) ? 0 : $urandom_range(0, max_gap));
  endtask

  task automatic send_noise();
    logic [7:0] b;
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == SYNC) b = 8'h5A;
      send_byte(b, $urandom_range(0, 2));
    end
  endtask

  // kind: 0 good, 1 bad checksum, 2 bad length, 3 truncated (timeout)
  task automatic build_frame(input int kind, input int len);
    int total;
    frame_q = {SYNC, 8'(len)};
    if (kind == 2) return;
    if (kind == 3) begin
      for (int i = 0; i < $urandom_range(0, len); i++) frame_q.push_back(8'($urandom_range(0, 255)));
      return;
    end
    total = len;
    for (int i = 0; i < len; i++) begin
      frame_q.push_back(8'($urandom_range(0, 255)));
      total += int'(frame_q[2 + i]);
    end
    if (kind == 1) frame_q.push_back(8'(total) ^ 8'($urandom_range(1, 255)));
    else frame_q.push_back(8'(total));
  endtask

  task automatic wait_idle(input int bound);
    int c;
    c = 0;
    while (o_Busy && c < bound) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("busy_clear", o_Busy, 0);
    @(negedge clk);
    #1;
    check("exp_q_empty", exp_q.size(), 0);
    check("err_q_empty", err_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic inject_overrun();
    err_q.push_back(E_OVR);
    send_byte(($urandom_range(0, 1) == 1) ? SYNC : 8'($urandom_range(0, 255)), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, o_Data_Valid, 0);
    check({tag, "_data"}, o_Data, 0);
    check({tag, "_last"}, o_Data_Last, 0);
    check({tag, "_busy"}, o_Busy, 0);
    check({tag, "_errs"}, {o_Err_Checksum, o_Err_Length, o_Err_Timeout, o_Err_Overrun}, 0);
  endtask

  initial begin
    int cnt;
    int kind;
    int len;

    #1 rst = 1'b1;
    #2 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("post_reset");

    // good packet, exact latency and back-to-back drain
    ready_mode = 0;
    frame_q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    model_frame();
    send_frame(2);
    check("first_latency", o_Data_Valid, 1);
    cnt = 0;
    while (o_Data_Valid && cnt < 50) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    check("drain_clocks", cnt, 3);
    wait_idle(100);

    // bad checksum then a good packet
    frame_q = {8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00};
    model_frame();
    send_frame(2);
    wait_idle(100);
    build_frame(0, 5);
    model_frame();
    send_frame(2);
    wait_idle(100);

    // length errors, then the maximum length
    frame_q = {8'hA5, 8'h00};
    model_frame();
    send_frame(2);
    wait_idle(100);
    frame_q = {8'hA5, 8'h11};
    model_frame();
    send_frame(2);
    wait_idle(100);
    build_frame(0, MAX_LEN);
    model_frame();
    send_frame(2);
    wait_idle(200);

    // timeout measured from the last strobe
    frame_q = {8'hA5, 8'h04, 8'h01, 8'h02};
    model_frame();
    send_frame(2);
    cnt = 0;
    while (!o_Err_Timeout && cnt < TMO + 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("timeout_clocks", cnt, TMO);
    wait_idle(100);

    // SYNC value as payload
    frame_q = {8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h4C};
    model_frame();
    send_frame(2);
    wait_idle(100);

    // backpressure pattern plus an overrun byte
    ready_mode = 2;
    tog_idx = 0;
    build_frame(0, 4);
    model_frame();
    send_frame(2);
    inject_overrun();
    wait_idle(200);

    // asynchronous reset mid-payload, then a good packet
    ready_mode = 0;
    frame_q = {8'hA5, 8'h05, 8'h01, 8'h02};
    send_frame(2);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_reset");
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    build_frame(0, 3);
    model_frame();
    send_frame(2);
    wait_idle(100);

    // randomized packets
    for (int p = 0; p < 30; p++) begin
      ready_mode = $urandom_range(0, 2);
      send_noise();
      kind = $urandom_range(0, 9);
      len = $urandom_range(1, MAX_LEN);
      if (kind == 0) build_frame(3, len);
      else if (kind == 1) build_frame(2, ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(MAX_LEN + 1, 255));
      else if (kind == 2) build_frame(1, len);
      else build_frame(0, len);
      model_frame();
      send_frame(3);
      if (kind >= 3 && $urandom_range(0, 2) == 0) inject_overrun();
      wait_idle(TMO + 500);
    end

    check("final_exp_q", exp_q.size(), 0);
    check("final_err_q", err_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
